fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DW, default 8, data bus width in bits.
REQ-002 Parameter AW, default 13, address width; instruction width SHALL be DW+DW = 16 = 3-bit opcode + AW address.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 data  input  DW  byte read from memory during instruction fetch.
REQ-006 ld_ir  input  1  from controller; load one instruction byte this cycle.
REQ-007 inc_pc  input  1  from controller; increment PC.
REQ-008 ld_pc  input  1  from controller; load PC from IR address field.
REQ-009 sel  input  1  from controller; 1 = drive PC onto addr, 0 = drive IR address field.
REQ-010 halt  input  1  from controller; request processor stop.
REQ-011 opcode  output  3  IR[15:13], fed back to controller.
REQ-012 ir_addr  output  AW  IR[12:0], operand address.
REQ-013 pc  output  AW  current program counter.
REQ-014 addr  output  AW  memory address.
REQ-015 ir_valid  output  1  one-cycle pulse: complete instruction loaded.
REQ-016 halted  output  1  sticky stop status.
REQ-017 fetch_err  output  1  sticky partial-fetch error.

Function
REQ-018 addr SHALL be combinational: sel ? pc : ir_addr.
REQ-019 A byte-phase flag SHALL track fetch: phase 0 = expect high byte, phase 1 = expect low byte.
REQ-020 ld_ir in phase 0 SHALL load data into IR[15:8] and set phase 1; IR[7:0] unchanged.
REQ-021 ld_ir in phase 1 SHALL load data into IR[7:0], clear phase to 0, and assert ir_valid for exactly the next cycle.
REQ-022 ld_ir low while phase 1 (partial fetch) SHALL clear phase to 0, set fetch_err, leave IR unchanged, and not assert ir_valid.
REQ-023 ld_pc SHALL load PC with ir_addr as registered at the start of that cycle.
REQ-024 inc_pc SHALL add 1 to PC modulo 2^AW; 0x1FFF wraps to 0x0000 with no flag.
REQ-025 ld_pc and inc_pc both high: ld_pc SHALL win; PC = ir_addr, no increment.
REQ-026 ld_ir and ld_pc in the same cycle: PC SHALL take the pre-load ir_addr; IR updates per REQ-020/021.
REQ-027 halt high at a posedge SHALL set halted; halted remains 1 until rst.
REQ-028 While halted (from the cycle after set), ld_ir, inc_pc, and ld_pc SHALL be ignored; PC, IR, and phase frozen; ir_valid 0; fetch_err not updated.
REQ-029 halt with inc_pc in the same cycle: the increment SHALL still occur, then freeze.
REQ-030 fetch_err SHALL be sticky until rst.

Reset
REQ-031 rst high SHALL immediately force PC=0, IR=0 (opcode=000, ir_addr=0), phase=0, ir_valid=0, halted=0, fetch_err=0, independent of clk.
REQ-032 rst asserted mid-fetch (phase 1) SHALL discard the high byte; the first ld_ir after release is treated as high byte.
REQ-033 First state change SHALL occur on the first posedge clk with rst low.

Structure
REQ-034 Shared package cpu_pkg SHALL hold DW, AW, and the opcode constants HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111, also used by the controller.
REQ-035 PC logic SHALL be a sub-module pc_counter (load, increment, wrap, freeze); IR, phase, and status logic stay in fetch_unit.
REQ-036 All flops SHALL be in clk/rst always blocks; addr, opcode, and ir_addr SHALL be purely combinational from registers.

Verification
REQ-037 Reset, then ld_ir 2 cycles with data 0xA0, 0x25 -> opcode=101, ir_addr=0x0025, ir_valid one pulse after 2nd byte, fetch_err=0.
REQ-038 PC=0x1FFF, inc_pc -> pc=0x0000; next inc_pc -> 0x0001; sel=1 gives addr=pc, sel=0 gives addr=ir_addr.
REQ-039 IR=0xE123 (JMP 0x0123), ld_pc and inc_pc together -> pc=0x0123.
REQ-040 ld_ir with 0x40, then ld_ir low -> fetch_err=1, phase 0, no ir_valid; next two ld_ir 0x60, 0x07 -> opcode=011, ir_addr=0x0007.
REQ-041 halt with inc_pc at pc=5 -> pc=6, halted=1; further ld_ir, inc_pc, ld_pc -> pc stays 6, IR unchanged.
REQ-042 Assert rst between the two fetch bytes -> all outputs 0 asynchronously; post-release fetch 0x20, 0x10 -> opcode=001, ir_addr=0x0010.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus/address widths and the opcode set used by
// the fetch unit and the controller.
package cpu_pkg;

    localparam int DW = 8;
    localparam int AW = 13;
    localparam int IW = DW + DW;
    localparam int OPW = IW - AW;

    typedef enum logic [2:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter: load from the IR address field, increment with silent
// wrap, and freeze once the processor has halted.
module pc_counter
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze_i,
    input  logic          ld_i,
    input  logic          inc_i,
    input  logic [AW-1:0] ld_val_i,
    output logic [AW-1:0] pc_o
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    // A load takes priority over an increment.
    always_comb begin
        pc_d = pc_q;
        if (!freeze_i) begin
            if (ld_i) begin
                pc_d = ld_val_i;
            end else if (inc_i) begin
                pc_d = pc_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Two-byte instruction fetch: assembles the IR high byte then low byte,
// tracks halt and partial-fetch status, and muxes the memory address.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data,
    input  logic          ld_ir,
    input  logic          inc_pc,
    input  logic          ld_pc,
    input  logic          sel,
    input  logic          halt,
    output logic [2:0]    opcode,
    output logic [AW-1:0] ir_addr,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] addr,
    output logic          ir_valid,
    output logic          halted,
    output logic          fetch_err
);

    localparam int IWL = DW + DW;

    logic [IWL-1:0] ir_q;
    logic [IWL-1:0] ir_d;
    logic           phase_q;
    logic           phase_d;
    logic           ir_valid_q;
    logic           ir_valid_d;
    logic           halted_q;
    logic           halted_d;
    logic           fetch_err_q;
    logic           fetch_err_d;

    // Phase 0 expects the high byte, phase 1 the low byte; dropping ld_ir
    // in phase 1 abandons the instruction and flags the error.
    always_comb begin
        ir_d        = ir_q;
        phase_d     = phase_q;
        ir_valid_d  = 1'b0;
        fetch_err_d = fetch_err_q;
        halted_d    = halted_q | halt;
        if (!halted_q) begin
            if (ld_ir) begin
                if (!phase_q) begin
                    ir_d = {data, ir_q[DW-1:0]};
                end else begin
                    ir_d       = {ir_q[IWL-1:DW], data};
                    ir_valid_d = 1'b1;
                end
                phase_d = ~phase_q;
            end else if (phase_q) begin
                phase_d     = 1'b0;
                fetch_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q        <= '0;
            phase_q     <= 1'b0;
            ir_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            phase_q     <= phase_d;
            ir_valid_q  <= ir_valid_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // The PC sees the pre-update IR address, so a simultaneous IR load
    // does not affect the jump target.
    pc_counter #(
        .AW(AW)
    ) u_pc_counter (
        .clk      (clk),
        .rst      (rst),
        .freeze_i (halted_q),
        .ld_i     (ld_pc),
        .inc_i    (inc_pc),
        .ld_val_i (ir_q[AW-1:0]),
        .pc_o     (pc)
    );

    assign opcode    = ir_q[IWL-1:AW];
    assign ir_addr   = ir_q[AW-1:0];
    assign addr      = sel ? pc : ir_addr;
    assign ir_valid  = ir_valid_q;
    assign halted    = halted_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random control
// traffic compared against an instruction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        ld_ir;
    logic        inc_pc;
    logic        ld_pc;
    logic        sel;
    logic        halt;
    logic [2:0]  opcode;
    logic [12:0] ir_addr;
    logic [12:0] pc;
    logic [12:0] addr;
    logic        ir_valid;
    logic        halted;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    // Reference model: whole instruction word and PC as plain integers.
    int mIr;
    int mPc;
    int mPhase;
    int mValid;
    int mHalted;
    int mErr;

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .sel       (sel),
        .halt      (halt),
        .opcode    (opcode),
        .ir_addr   (ir_addr),
        .pc        (pc),
        .addr      (addr),
        .ir_valid  (ir_valid),
        .halted    (halted),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".opcode"},    32'(opcode),    32'(mIr / 8192));
        check({tag, ".ir_addr"},   32'(ir_addr),   32'(mIr % 8192));
        check({tag, ".pc"},        32'(pc),        32'(mPc));
        check({tag, ".addr"},      32'(addr),      32'(sel ? mPc : mIr % 8192));
        check({tag, ".ir_valid"},  32'(ir_valid),  32'(mValid));
        check({tag, ".halted"},    32'(halted),    32'(mHalted));
        check({tag, ".fetch_err"}, 32'(fetch_err), 32'(mErr));
    endtask

    task automatic modelReset();
        mIr = 0; mPc = 0; mPhase = 0; mValid = 0; mHalted = 0; mErr = 0;
    endtask

    // One clock edge of architectural behaviour.
    task automatic modelStep(input logic li, input logic ip, input logic lp,
                             input logic h, input logic [7:0] d);
        int target;
        target = mIr % 8192;
        mValid = 0;
        if (mHalted == 0) begin
            if (li) begin
                if (mPhase == 0) begin
                    mIr = int'(d) * 256 + mIr % 256;
                    mPhase = 1;
                end else begin
                    mIr = (mIr / 256) * 256 + int'(d);
                    mPhase = 0;
                    mValid = 1;
                end
            end else if (mPhase == 1) begin
                mPhase = 0;
                mErr = 1;
            end
            if (lp) mPc = target;
            else if (ip) mPc = (mPc + 1) % 8192;
        end
        if (h) mHalted = 1;
    endtask

    task automatic applyStimulus(input logic li, input logic ip, input logic lp,
                                 input logic s, input logic h, input logic [7:0] d,
                                 input string tag);
        @(negedge clk);
        ld_ir = li; inc_pc = ip; ld_pc = lp; sel = s; halt = h; data = d;
        @(posedge clk);
        modelStep(li, ip, lp, h, d);
        #1;
        checkOutput(tag);
    endtask

    task automatic asyncReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        ld_ir = 0; inc_pc = 0; ld_pc = 0; halt = 0;
        rst = 1'b0;
    endtask

    task automatic randomRun(input int n, input int haltOdds, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                          haltOdds > 0 && $urandom_range(0, haltOdds - 1) == 0,
                          8'($urandom), tag);
        end
    endtask

    initial begin
        rst = 1'b1; ld_ir = 0; inc_pc = 0; ld_pc = 0; sel = 0; halt = 0; data = 8'h00;
        #1;
        modelReset();
        checkOutput("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic two-byte fetch: LDA 0x0025.
        applyStimulus(1, 0, 0, 0, 0, 8'hA0, "fetch1.hi");
        check("fetch1.hi_no_valid", 32'(ir_valid), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 8'h25, "fetch1.lo");
        check("fetch1.opcode", 32'(opcode), 32'b101);
        check("fetch1.ir_addr", 32'(ir_addr), 32'h0025);
        check("fetch1.valid", 32'(ir_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 8'h00, "fetch1.idle");
        check("fetch1.valid_pulse", 32'(ir_valid), 32'd0);
        check("fetch1.err", 32'(fetch_err), 32'd0);

        // PC wrap at the top of the address space.
        applyStimulus(1, 0, 0, 1, 0, 8'hFF, "wrap.hi");
        applyStimulus(1, 0, 0, 1, 0, 8'hFF, "wrap.lo");
        applyStimulus(0, 0, 1, 1, 0, 8'h00, "wrap.ldpc");
        check("wrap.pc_top", 32'(pc), 32'h1FFF);
        applyStimulus(0, 1, 0, 1, 0, 8'h00, "wrap.inc1");
        check("wrap.pc_zero", 32'(pc), 32'h0000);
        applyStimulus(0, 1, 0, 0, 0, 8'h00, "wrap.inc2");
        check("wrap.pc_one", 32'(pc), 32'h0001);
        check("wrap.addr_ir", 32'(addr), 32'h1FFF);

        // JMP 0x0123 with load and increment together: load wins.
        applyStimulus(1, 0, 0, 0, 0, 8'hE1, "jmp.hi");
        applyStimulus(1, 0, 0, 0, 0, 8'h23, "jmp.lo");
        applyStimulus(0, 1, 1, 1, 0, 8'h00, "jmp.ldinc");
        check("jmp.pc", 32'(pc), 32'h0123);

        // Load PC while loading a new high byte: target is the old address.
        applyStimulus(1, 0, 1, 1, 0, 8'h7C, "ldboth");
        check("ldboth.pc", 32'(pc), 32'h0123);

        // Partial fetch (ldboth left phase 1), then a clean one.
        applyStimulus(0, 0, 0, 0, 0, 8'h00, "partial0.abort");
        applyStimulus(1, 0, 0, 0, 0, 8'h40, "partial.hi");
        applyStimulus(0, 0, 0, 0, 0, 8'h00, "partial.abort");
        check("partial.err", 32'(fetch_err), 32'd1);
        check("partial.no_valid", 32'(ir_valid), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 8'h60, "refetch.hi");
        applyStimulus(1, 0, 0, 0, 0, 8'h07, "refetch.lo");
        check("refetch.opcode", 32'(opcode), 32'b011);
        check("refetch.ir_addr", 32'(ir_addr), 32'h0007);

        randomRun(400, 0, "rand1");

        // Reset between the two bytes discards the high byte.
        applyStimulus(1, 0, 0, 0, 0, 8'h55, "rstmid.hi");
        asyncReset("rstmid.async");
        applyStimulus(1, 0, 0, 0, 0, 8'h20, "rstmid.hi2");
        applyStimulus(1, 0, 0, 0, 0, 8'h10, "rstmid.lo2");
        check("rstmid.opcode", 32'(opcode), 32'b001);
        check("rstmid.ir_addr", 32'(ir_addr), 32'h0010);

        // Halt together with increment at pc=5, then freeze.
        applyStimulus(1, 0, 0, 0, 0, 8'h00, "halt.hi");
        applyStimulus(1, 0, 0, 0, 0, 8'h05, "halt.lo");
        applyStimulus(0, 0, 1, 1, 0, 8'h00, "halt.ldpc");
        check("halt.pc5", 32'(pc), 32'd5);
        applyStimulus(0, 1, 0, 1, 1, 8'h00, "halt.inc");
        check("halt.pc6", 32'(pc), 32'd6);
        check("halt.halted", 32'(halted), 32'd1);
        randomRun(40, 1, "halt.frozen");
        check("halt.pc_frozen", 32'(pc), 32'd6);
        check("halt.ir_frozen", 32'(ir_addr), 32'h0005);

        asyncReset("rst2.async");
        randomRun(300, 100, "rand2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
